// File: rtl/ped_signal_ctrl_pkg.sv
// Shared state type, default timing and lamp-pattern helper for the pedestrian controller.
// BEEP_HALF_DEF exists only in AUDIBLE_EN builds.
package ped_pkg;

   typedef enum logic [1:0] {
      STOP  = 2'd0,
      WALK  = 2'd1,
      FLASH = 2'd2,
      FAULT = 2'd3
   } state_t;

   localparam int unsigned CNT_W = 32;
   localparam int unsigned CD_W  = 8;

   localparam int unsigned WALK_CYCLES_DEF  = 6000000;
   localparam int unsigned FLASH_CYCLES_DEF = 3000000;
   localparam int unsigned FLASH_HALF_DEF   = 250000;
   localparam int unsigned SEC_CYCLES_DEF   = 1000000;
`ifdef AUDIBLE_EN
   localparam int unsigned BEEP_HALF_DEF    = 500;
`endif

   localparam int unsigned FAULT_PERSIST = 2;
   localparam int unsigned SYNC_STAGES   = 2;
   localparam int unsigned PERSIST_W     = $clog2(FAULT_PERSIST) + 1;

   // Exactly one lamp lit: odd count that is not all three.
   function automatic logic lamp_valid(input logic r, input logic b, input logic g);
      return (r ^ b ^ g) & ~(r & b & g);
   endfunction

endpackage

// File: rtl/ped_signal_ctrl_btn_sync_edge.sv
// Push-button synchronizer with a single-cycle rising-edge pulse.
module btn_sync_edge
   import ped_pkg::*;
#(
   parameter int unsigned STAGES = SYNC_STAGES
) (
   input  logic clock,
   input  logic reset,
   input  logic button,
   output logic rise_c
);

   logic [STAGES-1:0] sync;
   logic              prev;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync <= '0;
         prev <= 1'b0;
      end else begin
         sync <= {sync[STAGES-2:0], button};
         prev <= sync[STAGES-1];
      end
   end

   assign rise_c = sync[STAGES-1] & ~prev;

endmodule

// File: rtl/ped_signal_ctrl.sv
// Pedestrian WALK / flashing DON'T-WALK controller slaved to the vehicle lamp sequencer.
// Define AUDIBLE_EN to add the audible WALK tone on beep.
module ped_signal_ctrl
   import ped_pkg::*;
#(
   parameter int unsigned WALK_CYCLES  = WALK_CYCLES_DEF,
   parameter int unsigned FLASH_CYCLES = FLASH_CYCLES_DEF,
   parameter int unsigned FLASH_HALF   = FLASH_HALF_DEF,
   parameter int unsigned SEC_CYCLES   = SEC_CYCLES_DEF
`ifdef AUDIBLE_EN
   ,
   parameter int unsigned BEEP_HALF    = BEEP_HALF_DEF
`endif
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       veh_red,
   input  logic       veh_blue,
   input  logic       veh_green,
   input  logic       ped_button,
   output logic       walk,
   output logic       dont_walk,
   output logic       req_pending,
   output logic [7:0] countdown,
   output logic       fault,
   output logic       beep
);

   localparam logic [CD_W-1:0] CD_LOAD = CD_W'(FLASH_CYCLES / SEC_CYCLES);

   state_t                 state, state_d;
   logic [CNT_W-1:0]       cnt, cnt_d;
   logic [CNT_W-1:0]       sec_cnt, sec_d;
   logic [CNT_W-1:0]       fl_cnt, fl_d;
   logic [PERSIST_W-1:0]   inv_run, inv_d;
   logic                   red_q;
   logic                   walk_d, dw_d, req_d, fault_d;
   logic [CD_W-1:0]        cd_d;
   logic                   btn_rise;
   logic                   valid;
   logic                   fault_cond;
   logic                   red_rise;

   btn_sync_edge #(.STAGES(SYNC_STAGES)) u_btn (
      .clock  (clock),
      .reset  (reset),
      .button (ped_button),
      .rise_c (btn_rise)
   );

   assign valid      = lamp_valid(veh_red, veh_blue, veh_green);
   assign fault_cond = ~valid && (inv_run == PERSIST_W'(FAULT_PERSIST - 1));
   assign red_rise   = veh_red & ~red_q;
   assign inv_d      = valid ? '0 :
                       (inv_run == PERSIST_W'(FAULT_PERSIST - 1)) ? inv_run : inv_run + PERSIST_W'(1);

   // Next state, next counters and next registered outputs.
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      sec_d   = sec_cnt;
      fl_d    = fl_cnt;
      walk_d  = 1'b0;
      dw_d    = 1'b1;
      cd_d    = '0;
      fault_d = 1'b0;
      req_d   = req_pending;

      case (state)
         STOP:    if (red_rise && valid && req_pending) state_d = WALK;
         WALK:    if (!veh_red) state_d = STOP;
                  else if (cnt == '0) state_d = FLASH;
         FLASH:   if (!veh_red) state_d = STOP;
                  else if (cnt == '0) state_d = STOP;
         FAULT:   if (valid) state_d = STOP;
         default: state_d = STOP;
      endcase
      if (fault_cond) state_d = FAULT;

      case (state_d)
         WALK: begin
            walk_d = 1'b1;
            dw_d   = 1'b0;
            cnt_d  = (state != WALK) ? CNT_W'(WALK_CYCLES - 1) : cnt - CNT_W'(1);
         end
         FLASH: begin
            if (state != FLASH) begin
               cnt_d = CNT_W'(FLASH_CYCLES - 1);
               sec_d = CNT_W'(SEC_CYCLES - 1);
               fl_d  = CNT_W'(FLASH_HALF - 1);
               cd_d  = CD_LOAD;
            end else begin
               cnt_d = cnt - CNT_W'(1);
               dw_d  = dont_walk;
               cd_d  = countdown;
               if (fl_cnt == '0) begin
                  dw_d = ~dont_walk;
                  fl_d = CNT_W'(FLASH_HALF - 1);
               end else begin
                  fl_d = fl_cnt - CNT_W'(1);
               end
               // Seconds countdown saturates at zero.
               if (sec_cnt == '0) begin
                  sec_d = CNT_W'(SEC_CYCLES - 1);
                  if (countdown != '0) cd_d = countdown - CD_W'(1);
               end else begin
                  sec_d = sec_cnt - CNT_W'(1);
               end
            end
         end
         FAULT:   fault_d = 1'b1;
         default: ;
      endcase

      // Entering WALK serves the request and wins over a same-cycle new press.
      if (state_d == WALK && state != WALK) req_d = 1'b0;
      else if (btn_rise && state != WALK)   req_d = 1'b1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= STOP;
         cnt         <= '0;
         sec_cnt     <= '0;
         fl_cnt      <= '0;
         inv_run     <= '0;
         red_q       <= 1'b0;
         walk        <= 1'b0;
         dont_walk   <= 1'b1;
         req_pending <= 1'b0;
         countdown   <= '0;
         fault       <= 1'b0;
      end else begin
         state       <= state_d;
         cnt         <= cnt_d;
         sec_cnt     <= sec_d;
         fl_cnt      <= fl_d;
         inv_run     <= inv_d;
         red_q       <= veh_red;
         walk        <= walk_d;
         dont_walk   <= dw_d;
         req_pending <= req_d;
         countdown   <= cd_d;
         fault       <= fault_d;
      end
   end

`ifdef AUDIBLE_EN
   logic [CNT_W-1:0] beep_cnt, beep_cnt_d;
   logic             beep_d;

   // Tone restarts low on each WALK entry and is silenced outside WALK.
   always_comb begin
      beep_d     = 1'b0;
      beep_cnt_d = '0;
      if (state_d == WALK) begin
         if (state != WALK) begin
            beep_cnt_d = CNT_W'(BEEP_HALF - 1);
         end else if (beep_cnt == '0) begin
            beep_d     = ~beep;
            beep_cnt_d = CNT_W'(BEEP_HALF - 1);
         end else begin
            beep_d     = beep;
            beep_cnt_d = beep_cnt - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         beep     <= 1'b0;
         beep_cnt <= '0;
      end else begin
         beep     <= beep_d;
         beep_cnt <= beep_cnt_d;
      end
   end
`else
   assign beep = 1'b0;
`endif

endmodule
